// File: rtl/hilo_mdu_pkg.sv
// ---------------------------------------------------------------------------
// hilo_mdu_pkg
//
// Purpose:
//    Shared definitions for the HI/LO multiply/divide unit: operation codes,
//    FSM state encodings, default datapath width, iteration counter width and
//    small helpers that decode an operation code.
//
// Contents:
//    MDU_WIDTH    default operand / HI / LO width
//    MDU_CNT_W    iteration counter width, $clog2(MDU_WIDTH)+1
//    mdu_op_e     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
//    mdu_state_e  S_IDLE, S_RUN, S_FINISH
//    opIsDiv      1 for DIV/DIVU
//    opIsSigned   1 for MULT/DIV
// ---------------------------------------------------------------------------
package hilo_mdu_pkg;

   localparam int MDU_WIDTH = 32;
   localparam int MDU_CNT_W = $clog2(MDU_WIDTH) + 1;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_FINISH = 2'b10
   } mdu_state_e;

   // The upper opcode bit selects divide, the lower bit selects unsigned.
   function automatic logic opIsDiv(input mdu_op_e op);
      return op[1];
   endfunction

   function automatic logic opIsSigned(input mdu_op_e op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter
//
// Purpose:
//    One iteration step of the multi-cycle multiply/divide unit. Purely
//    combinational; the top level registers the results every RUN cycle.
//
//    Multiply: shift-add on a 2*width accumulator. The low half initially
//    holds the multiplier; each step conditionally adds the multiplicand into
//    the high half and shifts the whole accumulator right by one, so after
//    width steps the accumulator holds the full product.
//
//    Divide: restoring division. The low half of the accumulator holds the
//    dividend, consumed MSB first; the partial remainder is width+1 bits.
//    The quotient bit is returned separately and shifted in by the top level.
//
// Ports:
//    i_isDiv     1 = divide step, 0 = multiply step
//    i_acc       current accumulator (product, or dividend/quotient in low half)
//    i_rem       current partial remainder (divide only)
//    i_operand   multiplicand (multiply) or divisor (divide) magnitude
//    o_nextAcc   next accumulator for a multiply step (unchanged for divide)
//    o_nextRem   next partial remainder for a divide step (unchanged for multiply)
//    o_qBit      quotient bit produced by a divide step
// ---------------------------------------------------------------------------
module mdu_iter
   import hilo_mdu_pkg::*;
#(
   parameter int width = MDU_WIDTH
) (
   input  logic                 i_isDiv,
   input  logic [2*width-1:0]   i_acc,
   input  logic [width:0]       i_rem,
   input  logic [width-1:0]     i_operand,
   output logic [2*width-1:0]   o_nextAcc,
   output logic [width:0]       o_nextRem,
   output logic                 o_qBit
);

   logic [width:0]   w_mulSum;
   logic [width+1:0] w_shifted;
   logic [width+1:0] w_trial;

   // The multiply sum keeps its carry so the right shift brings it back into
   // the top of the accumulator. For divide, the trial subtraction is one bit
   // wider than the partial remainder so its MSB is a clean borrow flag: no
   // borrow means the divisor fits and the quotient bit is 1.
   always_comb begin
      w_mulSum  = {1'b0, i_acc[2*width-1:width]} +
                  (i_acc[0] ? {1'b0, i_operand} : '0);
      w_shifted = {i_rem, i_acc[width-1]};
      w_trial   = w_shifted - {2'b00, i_operand};
      o_qBit    = ~w_trial[width+1];

      o_nextAcc = i_acc;
      o_nextRem = i_rem;
      if (i_isDiv) begin
         o_nextRem = o_qBit ? w_trial[width:0] : w_shifted[width:0];
      end else begin
         o_nextAcc = {w_mulSum, i_acc[width-1:1]};
      end
   end

endmodule

// File: rtl/hilo_mdu.sv
// ---------------------------------------------------------------------------
// hilo_mdu
//
// Purpose:
//    Multi-cycle multiply/divide unit holding the architectural HI and LO
//    registers. Executes MULT, MULTU, DIV, DIVU (width+1 cycles each) and
//    MTHI/MTLO (single-cycle writes while idle). Signed operations are run on
//    magnitudes and the signs are fixed up in the FINISH cycle.
//
// Ports:
//    CLK     rising-edge clock
//    RST_N   synchronous active-low reset
//    Start   request an operation; sampled only in IDLE
//    Op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//    SrcA    multiplicand / dividend
//    SrcB    multiplier / divisor
//    WEHI    MTHI: write WD into HI (IDLE, Start low only)
//    WELO    MTLO: write WD into LO (IDLE, Start low only)
//    WD      MTHI/MTLO data
//    HI      high product / remainder (registered)
//    LO      low product / quotient (registered)
//    Busy    operation in flight (registered)
//    Done    one-cycle pulse alongside freshly written HI/LO (registered)
// ---------------------------------------------------------------------------
module hilo_mdu
   import hilo_mdu_pkg::*;
#(
   parameter int width = MDU_WIDTH
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               Start,
   input  logic [1:0]         Op,
   input  logic [width-1:0]   SrcA,
   input  logic [width-1:0]   SrcB,
   input  logic               WEHI,
   input  logic               WELO,
   input  logic [width-1:0]   WD,
   output logic [width-1:0]   HI,
   output logic [width-1:0]   LO,
   output logic               Busy,
   output logic               Done
);

   localparam int                CNT_W     = $clog2(width) + 1;
   localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(width - 1);

   mdu_state_e          r_state;
   logic                r_isDiv;
   logic [2*width-1:0]  r_acc;
   logic [width:0]      r_rem;
   logic [width-1:0]    r_operand;
   logic                r_prodNeg;
   logic                r_remNeg;
   logic                r_divZero;
   logic [CNT_W-1:0]    r_count;
   logic [width-1:0]    r_hi;
   logic [width-1:0]    r_lo;
   logic                r_busy;
   logic                r_done;

   mdu_op_e             w_opIn;
   logic                w_startIsDiv;
   logic                w_signA;
   logic                w_signB;
   logic [width-1:0]    w_magA;
   logic [width-1:0]    w_magB;
   logic [2*width-1:0]  w_nextAcc;
   logic [width:0]      w_nextRem;
   logic                w_qBit;
   logic [2*width-1:0]  w_product;
   logic [width-1:0]    w_quot;
   logic [width-1:0]    w_remRaw;
   logic [width-1:0]    w_quotFix;
   logic [width-1:0]    w_remFix;

   // Operand conditioning for a new request. Only the signed operations look
   // at the sign bits; unsigned operations pass the raw values through as
   // their "magnitudes". The most negative value negates to itself, which is
   // exactly its unsigned magnitude, so no special case is needed.
   always_comb begin
      w_opIn       = mdu_op_e'(Op);
      w_startIsDiv = opIsDiv(w_opIn);
      w_signA      = opIsSigned(w_opIn) & SrcA[width-1];
      w_signB      = opIsSigned(w_opIn) & SrcB[width-1];
      w_magA       = w_signA ? (-SrcA) : SrcA;
      w_magB       = w_signB ? (-SrcB) : SrcB;
   end

   // Sign fix-up of the finished magnitudes. The product is negated as one
   // 2*width value; quotient and remainder are negated independently, the
   // remainder taking the dividend's sign.
   always_comb begin
      w_product = r_prodNeg ? (-r_acc) : r_acc;
      w_quot    = r_acc[width-1:0];
      w_remRaw  = r_rem[width-1:0];
      w_quotFix = r_prodNeg ? (-w_quot) : w_quot;
      w_remFix  = r_remNeg ? (-w_remRaw) : w_remRaw;
   end

   mdu_iter #(
      .width      (width)
   ) u_iter (
      .i_isDiv    (r_isDiv),
      .i_acc      (r_acc),
      .i_rem      (r_rem),
      .i_operand  (r_operand),
      .o_nextAcc  (w_nextAcc),
      .o_nextRem  (w_nextRem),
      .o_qBit     (w_qBit)
   );

   // Main FSM: IDLE accepts a request or an MTHI/MTLO write, RUN performs
   // width iterations, FINISH applies the sign fix-up and writes HI/LO.
   // Busy covers the RUN and FINISH cycles; Done is a single-cycle pulse in
   // the cycle after FINISH, which is already IDLE, so a back-to-back Start
   // is accepted there. For divide the dividend bits leave the top of the low
   // accumulator half while quotient bits enter at the bottom.
   // A zero divisor naturally leaves the dividend in the remainder (so HI
   // comes back as SrcA after the sign fix-up), but the all-ones quotient
   // could be negated, so LO is forced to all ones in that case.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state   <= S_IDLE;
         r_isDiv   <= 1'b0;
         r_acc     <= '0;
         r_rem     <= '0;
         r_operand <= '0;
         r_prodNeg <= 1'b0;
         r_remNeg  <= 1'b0;
         r_divZero <= 1'b0;
         r_count   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_isDiv   <= w_startIsDiv;
                  r_prodNeg <= w_signA ^ w_signB;
                  r_remNeg  <= w_signA;
                  r_divZero <= (SrcB == '0);
                  r_count   <= '0;
                  r_rem     <= '0;
                  if (w_startIsDiv) begin
                     r_acc     <= {{width{1'b0}}, w_magA};
                     r_operand <= w_magB;
                  end else begin
                     r_acc     <= {{width{1'b0}}, w_magB};
                     r_operand <= w_magA;
                  end
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  if (WEHI) begin
                     r_hi <= WD;
                  end
                  if (WELO) begin
                     r_lo <= WD;
                  end
               end
            end

            S_RUN: begin
               if (r_isDiv) begin
                  r_acc <= {r_acc[2*width-1:width], r_acc[width-2:0], w_qBit};
                  r_rem <= w_nextRem;
               end else begin
                  r_acc <= w_nextAcc;
               end
               r_count <= r_count + 1'b1;
               if (r_count == LAST_ITER) begin
                  r_state <= S_FINISH;
               end
            end

            S_FINISH: begin
               if (r_isDiv) begin
                  r_lo <= r_divZero ? {width{1'b1}} : w_quotFix;
                  r_hi <= w_remFix;
               end else begin
                  r_hi <= w_product[2*width-1:width];
                  r_lo <= w_product[width-1:0];
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign HI   = r_hi;
   assign LO   = r_lo;
   assign Busy = r_busy;
   assign Done = r_done;

endmodule

// File: tb/tb_hilo_mdu.sv
// ---------------------------------------------------------------------------
// tb_hilo_mdu
//
// Purpose:
//    Self-checking bench for hilo_mdu. Every operation pushes its expected
//    {HI, LO} onto a scoreboard queue when Start is driven; the entry is
//    popped and compared when Done is observed. Inputs change just after the
//    falling edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hilo_mdu;

   localparam int W = 32;

   logic          CLK   = 1'b0;
   logic          RST_N = 1'b0;
   logic          Start = 1'b0;
   logic [1:0]    Op    = 2'b00;
   logic [W-1:0]  SrcA  = '0;
   logic [W-1:0]  SrcB  = '0;
   logic          WEHI  = 1'b0;
   logic          WELO  = 1'b0;
   logic [W-1:0]  WD    = '0;
   logic [W-1:0]  HI;
   logic [W-1:0]  LO;
   logic          Busy;
   logic          Done;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   exp_t          sb[$];
   int            checks   = 0;
   int            failures = 0;
   logic [W-1:0]  curHi    = '0;
   logic [W-1:0]  curLo    = '0;

   hilo_mdu #(
      .width (W)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .Start (Start),
      .Op    (Op),
      .SrcA  (SrcA),
      .SrcB  (SrcB),
      .WEHI  (WEHI),
      .WELO  (WELO),
      .WD    (WD),
      .HI    (HI),
      .LO    (LO),
      .Busy  (Busy),
      .Done  (Done)
   );

   // Free-running 10-time-unit clock.
   always #5 CLK = ~CLK;

   // Reference model built on the simulator's own arithmetic.
   function automatic exp_t modelOp(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
      exp_t                 e;
      logic [2*W-1:0]       p;
      logic signed [W-1:0]  sa;
      logic signed [W-1:0]  sb2;
      sa  = a;
      sb2 = b;
      case (op)
         2'b00: begin
            p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
            e = {p[2*W-1:W], p[W-1:0]};
         end
         2'b01: begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e = {p[2*W-1:W], p[W-1:0]};
         end
         2'b10: begin
            if (b == '0)                                    e = {a, {W{1'b1}}};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e = {{W{1'b0}}, a};
            else                                            e = {sa % sb2, sa / sb2};
         end
         default: begin
            if (b == '0) e = {a, {W{1'b1}}};
            else         e = {a % b, a / b};
         end
      endcase
      return e;
   endfunction

   task automatic tick;
      @(negedge CLK);
   endtask

   // Drive a one-cycle Start and record the expected result. Returns at the
   // falling edge right after the accepting edge, with Start low again.
   task automatic startOp(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t e);
      Start = 1'b1;
      Op    = op;
      SrcA  = a;
      SrcB  = b;
      sb.push_back(e);
      tick;
      Start = 1'b0;
   endtask

   // Wait (bounded) for Done, counting cycles waited and cycles with Busy high.
   task automatic waitDone(input int budget, output int cyc, output int busyCyc,
                           output bit timedOut);
      cyc     = 0;
      busyCyc = 0;
      while (Done !== 1'b1 && cyc < budget) begin
         if (Busy === 1'b1) busyCyc++;
         tick;
         cyc++;
      end
      timedOut = (Done !== 1'b1);
   endtask

   task automatic test_reset;
      RST_N = 1'b0;
      tick;
      tick;
      checks++; if (HI !== '0)   begin failures++; $display("[TB] FAIL reset_hi got=%h exp=0", HI); end
      checks++; if (LO !== '0)   begin failures++; $display("[TB] FAIL reset_lo got=%h exp=0", LO); end
      checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", Busy); end
      checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", Done); end
      RST_N = 1'b1;
      tick;
      curHi = '0;
      curLo = '0;
   endtask

   task automatic test_arith;
      logic [1:0]   tOp [16];
      logic [W-1:0] tA  [16];
      logic [W-1:0] tB  [16];
      exp_t         tE  [16];
      exp_t         e;
      int           cyc;
      int           busyCyc;
      bit           to;
      tOp[0] = 2'b01; tA[0] = 32'hFFFF_FFFF; tB[0] = 32'hFFFF_FFFF; tE[0] = {32'hFFFF_FFFE, 32'h0000_0001};
      tOp[1] = 2'b00; tA[1] = 32'hFFFF_FFFD; tB[1] = 32'd5;         tE[1] = {32'hFFFF_FFFF, 32'hFFFF_FFF1};
      tOp[2] = 2'b00; tA[2] = 32'h8000_0000; tB[2] = 32'h8000_0000; tE[2] = {32'h4000_0000, 32'h0000_0000};
      tOp[3] = 2'b10; tA[3] = 32'hFFFF_FFF9; tB[3] = 32'd2;         tE[3] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
      tOp[4] = 2'b11; tA[4] = 32'd7;         tB[4] = 32'd0;         tE[4] = {32'h0000_0007, 32'hFFFF_FFFF};
      tOp[5] = 2'b10; tA[5] = 32'h8000_0000; tB[5] = 32'hFFFF_FFFF; tE[5] = {32'h0000_0000, 32'h8000_0000};
      tOp[6] = 2'b10; tA[6] = 32'hFFFF_FFF9; tB[6] = 32'd0;         tE[6] = {32'hFFFF_FFF9, 32'hFFFF_FFFF};
      tOp[7] = 2'b11; tA[7] = 32'd100;       tB[7] = 32'd7;         tE[7] = {32'h0000_0002, 32'h0000_000E};
      tOp[8] = 2'b10; tA[8] = 32'd100;       tB[8] = 32'hFFFF_FFF9; tE[8] = {32'h0000_0002, 32'hFFFF_FFF2};
      tOp[9] = 2'b01; tA[9] = 32'h0001_0000; tB[9] = 32'h0001_0000; tE[9] = {32'h0000_0001, 32'h0000_0000};
      for (int i = 10; i < 16; i++) begin
         tOp[i] = 2'($urandom_range(0, 3));
         tA[i]  = $urandom;
         tB[i]  = $urandom;
         if (i == 10) tB[i] = '0;
         if (i == 11) tB[i] = tB[i] >> 20;
         tE[i]  = modelOp(tOp[i], tA[i], tB[i]);
      end
      for (int i = 0; i < 16; i++) begin
         startOp(tOp[i], tA[i], tB[i], tE[i]);
         waitDone(60, cyc, busyCyc, to);
         checks++; if (to) begin failures++; $display("[TB] FAIL arith%0d_timeout done=%b exp=1", i, Done); end
         checks++; if (cyc != 33) begin failures++; $display("[TB] FAIL arith%0d_latency got=%0d exp=33", i, cyc); end
         checks++; if (busyCyc != 33) begin failures++; $display("[TB] FAIL arith%0d_busy_cycles got=%0d exp=33", i, busyCyc); end
         if (sb.size() == 0) begin
            checks++; failures++; $display("[TB] FAIL arith%0d_scoreboard_empty", i);
         end else begin
            e = sb.pop_front();
            checks++; if (HI !== e.hi) begin failures++; $display("[TB] FAIL arith%0d_hi op=%b a=%h b=%h got=%h exp=%h", i, tOp[i], tA[i], tB[i], HI, e.hi); end
            checks++; if (LO !== e.lo) begin failures++; $display("[TB] FAIL arith%0d_lo op=%b a=%h b=%h got=%h exp=%h", i, tOp[i], tA[i], tB[i], LO, e.lo); end
            curHi = e.hi;
            curLo = e.lo;
         end
         checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL arith%0d_busy_at_done got=%b exp=0", i, Busy); end
         tick;
         checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL arith%0d_done_width got=%b exp=0", i, Done); end
      end
   endtask

   task automatic test_mthilo;
      exp_t e;
      int   cyc;
      int   busyCyc;
      bit   to;
      WEHI = 1'b1; WD = 32'h0000_1234;
      tick;
      WEHI = 1'b0;
      checks++; if (HI !== 32'h0000_1234) begin failures++; $display("[TB] FAIL mthi_hi got=%h exp=00001234", HI); end
      checks++; if (LO !== curLo) begin failures++; $display("[TB] FAIL mthi_lo_kept got=%h exp=%h", LO, curLo); end
      WELO = 1'b1; WD = 32'h0000_5678;
      tick;
      WELO = 1'b0;
      checks++; if (LO !== 32'h0000_5678) begin failures++; $display("[TB] FAIL mtlo_lo got=%h exp=00005678", LO); end
      checks++; if (HI !== 32'h0000_1234) begin failures++; $display("[TB] FAIL mtlo_hi_kept got=%h exp=00001234", HI); end
      WEHI = 1'b1; WELO = 1'b1; WD = 32'hABCD_0001;
      tick;
      WEHI = 1'b0; WELO = 1'b0;
      checks++; if (HI !== 32'hABCD_0001) begin failures++; $display("[TB] FAIL mtboth_hi got=%h exp=abcd0001", HI); end
      checks++; if (LO !== 32'hABCD_0001) begin failures++; $display("[TB] FAIL mtboth_lo got=%h exp=abcd0001", LO); end
      curHi = 32'hABCD_0001;
      curLo = 32'hABCD_0001;
      // Start and MTHI/MTLO in the same cycle: the operation wins.
      WEHI = 1'b1; WELO = 1'b1; WD = 32'hDEAD_BEEF;
      startOp(2'b01, 32'd6, 32'd7, {32'h0, 32'd42});
      WEHI = 1'b0; WELO = 1'b0;
      checks++; if (HI !== curHi) begin failures++; $display("[TB] FAIL start_wins_hi got=%h exp=%h", HI, curHi); end
      checks++; if (LO !== curLo) begin failures++; $display("[TB] FAIL start_wins_lo got=%h exp=%h", LO, curLo); end
      waitDone(60, cyc, busyCyc, to);
      checks++; if (to) begin failures++; $display("[TB] FAIL start_wins_timeout done=%b exp=1", Done); end
      if (sb.size() == 0) begin
         checks++; failures++; $display("[TB] FAIL start_wins_scoreboard_empty");
      end else begin
         e = sb.pop_front();
         checks++; if (HI !== e.hi) begin failures++; $display("[TB] FAIL start_wins_result_hi got=%h exp=%h", HI, e.hi); end
         checks++; if (LO !== e.lo) begin failures++; $display("[TB] FAIL start_wins_result_lo got=%h exp=%h", LO, e.lo); end
         curHi = e.hi;
         curLo = e.lo;
      end
      tick;
   endtask

   task automatic test_wehi_midrun;
      exp_t e;
      int   cyc;
      int   busyCyc;
      bit   to;
      startOp(2'b01, 32'd3, 32'd4, {32'h0, 32'd12});
      repeat (5) tick;
      WEHI = 1'b1; WELO = 1'b1; WD = 32'hFFFF_0000;
      tick;
      WEHI = 1'b0; WELO = 1'b0;
      checks++; if (HI !== curHi) begin failures++; $display("[TB] FAIL midrun_wehi_hi_held got=%h exp=%h", HI, curHi); end
      checks++; if (LO !== curLo) begin failures++; $display("[TB] FAIL midrun_welo_lo_held got=%h exp=%h", LO, curLo); end
      waitDone(60, cyc, busyCyc, to);
      checks++; if (to) begin failures++; $display("[TB] FAIL midrun_wehi_timeout done=%b exp=1", Done); end
      if (sb.size() == 0) begin
         checks++; failures++; $display("[TB] FAIL midrun_wehi_scoreboard_empty");
      end else begin
         e = sb.pop_front();
         checks++; if (HI !== e.hi) begin failures++; $display("[TB] FAIL midrun_wehi_final_hi got=%h exp=%h", HI, e.hi); end
         checks++; if (LO !== e.lo) begin failures++; $display("[TB] FAIL midrun_wehi_final_lo got=%h exp=%h", LO, e.lo); end
         curHi = e.hi;
         curLo = e.lo;
      end
      tick;
   endtask

   task automatic test_start_midrun;
      exp_t e;
      int   cyc;
      int   busyCyc;
      bit   to;
      bit   extraDone;
      startOp(2'b11, 32'd1000, 32'd3, {32'd1, 32'd333});
      repeat (8) tick;
      Start = 1'b1; Op = 2'b00; SrcA = 32'd5; SrcB = 32'd6;
      tick;
      Start = 1'b0;
      waitDone(60, cyc, busyCyc, to);
      checks++; if (to) begin failures++; $display("[TB] FAIL start_midrun_timeout done=%b exp=1", Done); end
      if (sb.size() == 0) begin
         checks++; failures++; $display("[TB] FAIL start_midrun_scoreboard_empty");
      end else begin
         e = sb.pop_front();
         checks++; if (HI !== e.hi) begin failures++; $display("[TB] FAIL start_midrun_hi got=%h exp=%h", HI, e.hi); end
         checks++; if (LO !== e.lo) begin failures++; $display("[TB] FAIL start_midrun_lo got=%h exp=%h", LO, e.lo); end
         curHi = e.hi;
         curLo = e.lo;
      end
      extraDone = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (Done === 1'b1) extraDone = 1'b1;
      end
      checks++; if (extraDone !== 1'b0) begin failures++; $display("[TB] FAIL start_midrun_queued_op got_done=%b exp=0", extraDone); end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   cyc;
      int   busyCyc;
      bit   to;
      startOp(2'b00, 32'd7, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'hFFFF_FFF2});
      waitDone(60, cyc, busyCyc, to);
      checks++; if (to) begin failures++; $display("[TB] FAIL b2b_first_timeout done=%b exp=1", Done); end
      if (sb.size() == 0) begin
         checks++; failures++; $display("[TB] FAIL b2b_first_scoreboard_empty");
      end else begin
         e = sb.pop_front();
         checks++; if (HI !== e.hi) begin failures++; $display("[TB] FAIL b2b_first_hi got=%h exp=%h", HI, e.hi); end
         checks++; if (LO !== e.lo) begin failures++; $display("[TB] FAIL b2b_first_lo got=%h exp=%h", LO, e.lo); end
      end
      // Start driven in the Done cycle.
      startOp(2'b11, 32'hFFFF_FFFF, 32'd10, {32'd5, 32'h1999_9999});
      waitDone(60, cyc, busyCyc, to);
      checks++; if (to) begin failures++; $display("[TB] FAIL b2b_second_timeout done=%b exp=1", Done); end
      checks++; if (cyc + 1 != 34) begin failures++; $display("[TB] FAIL b2b_done_spacing got=%0d exp=34", cyc + 1); end
      if (sb.size() == 0) begin
         checks++; failures++; $display("[TB] FAIL b2b_second_scoreboard_empty");
      end else begin
         e = sb.pop_front();
         checks++; if (HI !== e.hi) begin failures++; $display("[TB] FAIL b2b_second_hi got=%h exp=%h", HI, e.hi); end
         checks++; if (LO !== e.lo) begin failures++; $display("[TB] FAIL b2b_second_lo got=%h exp=%h", LO, e.lo); end
         curHi = e.hi;
         curLo = e.lo;
      end
      tick;
   endtask

   task automatic test_reset_midrun;
      bit sawDone;
      startOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
      repeat (9) tick;
      RST_N = 1'b0;
      tick;
      RST_N = 1'b1;
      checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_midrun_busy got=%b exp=0", Busy); end
      checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL rst_midrun_done got=%b exp=0", Done); end
      checks++; if (HI !== '0) begin failures++; $display("[TB] FAIL rst_midrun_hi got=%h exp=0", HI); end
      checks++; if (LO !== '0) begin failures++; $display("[TB] FAIL rst_midrun_lo got=%h exp=0", LO); end
      sb.delete();
      curHi = '0;
      curLo = '0;
      sawDone = 1'b0;
      for (int i = 0; i < 45; i++) begin
         tick;
         if (Done === 1'b1) sawDone = 1'b1;
      end
      checks++; if (sawDone !== 1'b0) begin failures++; $display("[TB] FAIL rst_midrun_abandoned got_done=%b exp=0", sawDone); end
      checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_midrun_idle_busy got=%b exp=0", Busy); end
      checks++; if (HI !== curHi) begin failures++; $display("[TB] FAIL rst_midrun_hi_after got=%h exp=%h", HI, curHi); end
   endtask

   // Test sequence followed by the one-line summary.
   initial begin
      test_reset;
      test_arith;
      test_mthilo;
      test_wehi_midrun;
      test_start_midrun;
      test_back_to_back;
      test_reset_midrun;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
